// File: rtl/frecip_nr_seq_pkg.sv
// Shared definitions for the Newton-Raphson reciprocal sequencer:
// FSM states, Q2.62 constants and the product slice helper.
package frecip_nr_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TBL,
    M1,
    W1,
    M2,
    W2,
    DONE,
    OUT
  } frecip_st_t;

  localparam logic [63:0] Q62_TWO = 64'h8000_0000_0000_0000;
  localparam logic [2:0] FRECIP_TBL_XTRA = 3'd0;

  // Q4.124 product viewed as Q2.62; the integer bits are kept so
  // that d*x >= 1.0 and x >= 1.0 remain representable.
  function automatic logic [63:0] q62_slice(
    input logic [127:0] p
  );
    return p[125:62];
  endfunction

endpackage

// File: rtl/frecip_mul_port.sv
// Request/grant side of the shared 64x64 multiplier: holds the
// operands stable until grant and qualifies the product pulse.
module frecip_mul_port
  import frecip_nr_seq_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         issue,
  input  logic [63:0]  op_a,
  input  logic [63:0]  op_b,
  input  logic         mul_gnt,
  input  logic         mul_rvalid,
  input  logic [127:0] mul_res,
  output logic         mul_req,
  output logic [63:0]  mul_a,
  output logic [63:0]  mul_b,
  output logic         gnt_fire,
  output logic         rsp_fire,
  output logic [63:0]  rsp_q62
);

  logic pend_q;
  logic unused_res;

  assign gnt_fire = mul_req & mul_gnt;
  assign rsp_fire = pend_q & mul_rvalid;
  assign rsp_q62 = q62_slice(mul_res);
  assign unused_res = ^{mul_res[127:126], mul_res[61:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      mul_req <= 1'b0;
      pend_q <= 1'b0;
      mul_a <= '0;
      mul_b <= '0;
    end else begin
      if (issue) begin
        mul_req <= 1'b1;
        mul_a <= op_a;
        mul_b <= op_b;
      end else if (gnt_fire) begin
        mul_req <= 1'b0;
      end
      if (gnt_fire) begin
        pend_q <= 1'b1;
      end else if (rsp_fire) begin
        pend_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/frecip_nr_seq.sv
// Seeded Newton-Raphson reciprocal mantissa sequencer on a shared
// multiplier. Optional perf_cycles port: define FRECIP_CYCLE_CNT_EN.
module frecip_nr_seq
  import frecip_nr_seq_pkg::*;
#(
  parameter int ITERS = 3,
  parameter int TAGW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [67:0]     in_a,
  output logic            tbl_is_read,
  output logic [2:0]      tbl_xtra,
  output logic [67:0]     tbl_a,
  input  logic [67:0]     tbl_res,
  output logic            mul_req,
  input  logic            mul_gnt,
  output logic [63:0]     mul_a,
  output logic [63:0]     mul_b,
  input  logic            mul_rvalid,
  input  logic [127:0]    mul_res,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [52:0]     out_mant,
  output logic            out_exp_dec,
  output logic [TAGW-1:0] out_tag
`ifdef FRECIP_CYCLE_CNT_EN
  ,
  output logic [31:0]     perf_cycles
`endif
);

  localparam logic [2:0] LAST = 3'(ITERS - 1);

  frecip_st_t  st;
  logic [67:0] a_q;
  logic        zero_q;
  logic [63:0] d_q;
  logic [63:0] x_q;
  logic [2:0]  it_q;

  logic        issue;
  logic [63:0] op_a;
  logic [63:0] op_b;
  logic        gnt_fire;
  logic        rsp_fire;
  logic [63:0] rsp_q62;
  logic [63:0] x0_w;
  logic [63:0] d_w;
  logic [63:0] t_w;
  logic [52:0] res_mant;
  logic        res_dec;
  logic        unused_tbl;

  assign tbl_xtra = FRECIP_TBL_XTRA;
  assign tbl_a = a_q;
  assign x0_w = {3'b001, tbl_res[52:0], 8'b0};
  assign d_w = {2'b01, a_q[52:0], 9'b0};
  assign t_w = Q62_TWO - rsp_q62;
  assign unused_tbl = ^tbl_res[67:53];

  always_comb begin
    issue = 1'b0;
    op_a = d_q;
    op_b = x_q;
    unique case (st)
      TBL: begin
        issue = 1'b1;
        op_a = d_w;
        op_b = x0_w;
      end
      W1: begin
        issue = rsp_fire;
        op_a = x_q;
        op_b = t_w;
      end
      W2: begin
        issue = rsp_fire && (it_q != LAST);
        op_a = d_q;
        op_b = rsp_q62;
      end
      default: ;
    endcase
  end

  // x sits in [0.5, 1.0) normally; its leading 0.5 bit is dropped
  always_comb begin
    res_mant = x_q[60:8];
    res_dec = 1'b1;
    if (zero_q) begin
      res_mant = '0;
      res_dec = 1'b0;
    end else if (|x_q[63:62]) begin
      res_mant = '1;
    end else if (!x_q[61]) begin
      res_mant = '0;
    end
  end

  frecip_mul_port u_mul_port (
    .clk        (clk),
    .rst        (rst),
    .issue      (issue),
    .op_a       (op_a),
    .op_b       (op_b),
    .mul_gnt    (mul_gnt),
    .mul_rvalid (mul_rvalid),
    .mul_res    (mul_res),
    .mul_req    (mul_req),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .gnt_fire   (gnt_fire),
    .rsp_fire   (rsp_fire),
    .rsp_q62    (rsp_q62)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      in_ready <= 1'b1;
      tbl_is_read <= 1'b0;
      out_valid <= 1'b0;
      out_mant <= '0;
      out_exp_dec <= 1'b0;
      out_tag <= '0;
      it_q <= '0;
      a_q <= '0;
      zero_q <= 1'b0;
      d_q <= '0;
      x_q <= '0;
    end else begin
      unique case (st)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_q <= in_a;
            zero_q <= (in_a[52:0] == '0);
            in_ready <= 1'b0;
            it_q <= '0;
            if (in_a[52:0] == '0) begin
              st <= DONE;
            end else begin
              st <= TBL;
              tbl_is_read <= 1'b1;
            end
          end
        end
        TBL: begin
          tbl_is_read <= 1'b0;
          d_q <= d_w;
          x_q <= x0_w;
          st <= M1;
        end
        M1: if (gnt_fire) st <= W1;
        W1: if (rsp_fire) st <= M2;
        M2: if (gnt_fire) st <= W2;
        W2: begin
          if (rsp_fire) begin
            x_q <= rsp_q62;
            it_q <= it_q + 3'd1;
            st <= (it_q == LAST) ? DONE : M1;
          end
        end
        DONE: begin
          out_mant <= res_mant;
          out_exp_dec <= res_dec;
          out_tag <= a_q[66 +: TAGW];
          out_valid <= 1'b1;
          st <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready <= 1'b1;
            st <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

`ifdef FRECIP_CYCLE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles <= '0;
    end else if (st != IDLE && perf_cycles != '1) begin
      perf_cycles <= perf_cycles + 32'd1;
    end
  end
`endif

endmodule
